inst_fetch_unit: RTL and testbench

- Instruction fetch stage. Owns the PC, fetches 32-bit words from instruction memory over a req/ack handshake, and holds each word in an instruction register.
- Presents the held instruction, plus the 6-bit control code the control decoder consumes, to decode under a valid/ready handshake.
- Takes the decoder's Branch (qualified with ALU Zero) and Jump results back to compute the next PC.
- Sits between instruction memory and the control/decode logic.

---
 rtl/inst_fetch_unit_if.sv | 38 +++
 rtl/inst_fetch_unit.sv | 148 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - bus bundle between fetch stage, instruction memory and decode
//
// Purpose: groups the instruction-memory req/ack bus, the decode valid/ready
// handshake and the branch/jump feedback into one bundle.
// Signals:
//   imem_req, imem_addr     fetch request and byte address (fetch -> memory)
//   imem_ack, imem_rdata    memory response, data valid while ack=1 (memory -> fetch)
//   inst, ctrl_code         held instruction and decoder control code (fetch -> decode)
//   pc_out, pc_plus4        address of held instruction and its successor (fetch -> decode)
//   inst_valid, inst_ready  decode handshake
//   branch_taken, jump      next-PC selection for the held instruction (decode -> fetch)
//   fetch_err               sticky memory-timeout fault (fetch -> system)
// Modports: master = fetch unit side, slave = memory/decode environment side.
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [5:0]  ctrl_code;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        inst_valid;
  logic        inst_ready;
  logic        branch_taken;
  logic        jump;
  logic        fetch_err;

  modport master (
    output imem_req, imem_addr, inst, ctrl_code, pc_out, pc_plus4, inst_valid, fetch_err,
    input  imem_ack, imem_rdata, inst_ready, branch_taken, jump
  );

  modport slave (
    input  imem_req, imem_addr, inst, ctrl_code, pc_out, pc_plus4, inst_valid, fetch_err,
    output imem_ack, imem_rdata, inst_ready, branch_taken, jump
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction fetch stage: PC, imem req/ack fetch, instruction register
//
// Purpose: owns the PC, fetches one 32-bit word per request over a req/ack
// bus, holds it for decode under valid/ready, and updates the PC from the
// decoder's jump / branch_taken feedback when the instruction is consumed.
// Ports:
//   clk      input   system clock, rising edge
//   reset_n  input   synchronous active-low reset
//   bus      master  inst_fetch_unit_if: imem_req/imem_addr/imem_ack/imem_rdata,
//                    inst/ctrl_code/pc_out/pc_plus4/inst_valid/inst_ready,
//                    branch_taken/jump, fetch_err
// Parameters:
//   RESET_PC  PC loaded on reset
//   TIMEOUT   REQ cycles without ack before the sticky fault; 0 waits forever
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  inst_fetch_unit_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  // Counter only has to reach TIMEOUT-1, so size it for that value.
  localparam int unsigned     CNT_W      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam bit              TIMEOUT_EN = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  // The PC is word aligned by construction; misaligned RESET_PC bits are dropped.
  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t           state_q;
  logic [31:0]      pc_q;
  logic [31:0]      inst_q;
  logic [CNT_W-1:0] cnt_q;
  logic             imem_req_q;
  logic             inst_valid_q;
  logic             fetch_err_q;

  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] jmp_target;
  logic [31:0] next_pc_d;
  logic [5:0]  ctrl_code;

  // Sequential PC wraps naturally at 32 bits (0xFFFF_FFFC -> 0).
  assign pc_plus4 = pc_q + 32'd4;

  // Branch offset: sign-extended word offset relative to pc+4.
  assign br_offset  = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};
  assign br_target  = pc_plus4 + br_offset;

  // Jump stays inside the 256 MB region selected by pc+4.
  assign jmp_target = {pc_plus4[31:28], inst_q[25:0], 2'b00};

  // Jump has priority over a taken branch.
  always_comb begin
    next_pc_d = pc_plus4;
    if (bus.jump) begin
      next_pc_d = jmp_target;
    end else if (bus.branch_taken) begin
      next_pc_d = br_target;
    end
  end

  // R-type instructions (opcode 0) are distinguished by their funct field.
  assign ctrl_code = (inst_q[31:26] == 6'd0) ? inst_q[5:0] : inst_q[31:26];

  // Control FSM. Handshake outputs are registered alongside the state so
  // they change only on the clock edge that enters the corresponding state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC_W;
      inst_q       <= 32'd0;
      cnt_q        <= '0;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= REQ;
          imem_req_q <= 1'b1;
        end

        REQ: begin
          if (bus.imem_ack) begin
            inst_q       <= bus.imem_rdata;
            cnt_q        <= '0;
            state_q      <= HOLD;
            imem_req_q   <= 1'b0;
            inst_valid_q <= 1'b1;
          end else if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
            // This cycle is the TIMEOUT-th REQ cycle without a response.
            state_q     <= ERR;
            imem_req_q  <= 1'b0;
            fetch_err_q <= 1'b1;
          end else if (TIMEOUT_EN) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        HOLD: begin
          // branch_taken/jump only matter in this consume cycle.
          if (bus.inst_ready) begin
            pc_q         <= next_pc_d;
            state_q      <= REQ;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b1;
          end
        end

        ERR: begin
          // Fault is sticky; only reset leaves this state.
          state_q      <= ERR;
          imem_req_q   <= 1'b0;
          inst_valid_q <= 1'b0;
          fetch_err_q  <= 1'b1;
        end

        default: begin
          state_q      <= IDLE;
          imem_req_q   <= 1'b0;
          inst_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.ctrl_code  = ctrl_code;
  assign bus.pc_out     = pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.inst_valid = inst_valid_q;
  assign bus.fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - scoreboard testbench for inst_fetch_unit
module tb_inst_fetch_unit;

  localparam longint M32 = 64'h1_0000_0000;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [5:0]  ctrl;
  } exp_t;

  typedef struct {
    int          delay;
    int          stall;
    bit          bt;
    bit          jmp;
    bit          chk;
    logic [5:0]  ctrl;
    logic [31:0] nxt;
  } plan_t;

  logic clk;
  logic reset_n;
  logic rb_n;

  inst_fetch_unit_if ifa ();
  inst_fetch_unit_if ifb ();

  inst_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(4)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ifa)
  );

  inst_fetch_unit #(.RESET_PC(32'hF000_0000), .TIMEOUT(0)) dut_b (
    .clk     (clk),
    .reset_n (rb_n),
    .bus     (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;
  bit abort  = 1'b0;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  int          req_len_q[$];
  int          hold_len_q[$];
  plan_t       plan_q[$];
  logic [31:0] mem [logic [31:0]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur at %0t", nm, $time);
  endtask

  // Reference model, written from the instruction-format rules.
  function automatic logic [5:0] model_ctrl(input logic [31:0] w);
    longint op;
    longint funct;
    op    = longint'(w) / 64'd67108864;
    funct = longint'(w) % 64'd64;
    return (op == 0) ? 6'(funct) : 6'(op);
  endfunction

  function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                             input bit bt, input bit jp);
    longint seq;
    longint off;
    seq = (longint'(pc) + 4) % M32;
    if (jp) return 32'((seq / 64'd268435456) * 64'd268435456 + (longint'(w) % 64'd67108864) * 4);
    if (bt) begin
      off = longint'(w) % 64'd65536;
      if (off >= 32768) off = off - 65536;
      return 32'((seq + off * 4 + M32) % M32);
    end
    return 32'(seq);
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] w;
    if (!mem.exists(a)) begin
      w = $urandom;
      if ($urandom_range(0, 3) == 0) w[31:26] = 6'd0;
      mem[a] = w;
    end
    return mem[a];
  endfunction

  // Driver: plays instruction memory and decoder for DUT A and pushes
  // the expected responses into the scoreboard queues.
  task automatic run_fetch(input int n);
    logic [31:0] pc_m;
    pc_m = 32'h0;
    for (int k = 0; k < n; k++) begin
      plan_t       p;
      logic [31:0] w;
      int          g;
      g = 0;
      while (!ifa.imem_req && g < 40) begin
        @(negedge clk);
        g++;
      end
      if (!ifa.imem_req) begin
        fail_now("driver_wait_req");
        abort = 1'b1;
        break;
      end
      if (plan_q.size() > 0) begin
        p = plan_q.pop_front();
      end else begin
        p.delay = $urandom_range(0, 3);
        p.stall = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 5);
        p.bt    = ($urandom_range(0, 3) == 0);
        p.jmp   = ($urandom_range(0, 4) == 0);
        p.chk   = 1'b0;
        p.ctrl  = 6'd0;
        p.nxt   = 32'd0;
      end
      repeat (p.delay) @(negedge clk);
      w = mem_rd(pc_m);
      ifa.imem_ack   = 1'b1;
      ifa.imem_rdata = w;
      exp_q.push_back('{inst: w, pc: pc_m, ctrl: (p.chk ? p.ctrl : model_ctrl(w))});
      req_len_q.push_back(p.delay + 1);
      @(negedge clk);
      ifa.imem_ack   = 1'b0;
      ifa.imem_rdata = $urandom;
      for (int s = 0; s < p.stall; s++) begin
        if ($urandom_range(0, 2) == 0) begin
          ifa.imem_ack   = 1'b1;
          ifa.imem_rdata = $urandom;
        end
        @(negedge clk);
        ifa.imem_ack = 1'b0;
      end
      ifa.inst_ready   = 1'b1;
      ifa.branch_taken = p.bt;
      ifa.jump         = p.jmp;
      pc_m = p.chk ? p.nxt : model_next(pc_m, w, p.bt, p.jmp);
      addr_q.push_back(pc_m);
      hold_len_q.push_back(p.stall + 1);
      @(negedge clk);
      ifa.inst_ready   = 1'b0;
      ifa.branch_taken = 1'($urandom_range(0, 1));
      ifa.jump         = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: pops and compares whenever DUT A presents a request or an instruction.
  initial begin
    bit          prev_req;
    bit          prev_val;
    int          req_run;
    int          val_run;
    logic [31:0] h_addr;
    logic [31:0] h_inst;
    logic [31:0] h_pc;
    exp_t        e;
    prev_req = 1'b0;
    prev_val = 1'b0;
    req_run  = 0;
    val_run  = 0;
    h_addr   = '0;
    h_inst   = '0;
    h_pc     = '0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        prev_req = 1'b0;
        prev_val = 1'b0;
        req_run  = 0;
        val_run  = 0;
      end else begin
        if (ifa.imem_req) begin
          if (!prev_req) begin
            if (addr_q.size() == 0) fail_now("sb_addr_available");
            else check("imem_addr", ifa.imem_addr, addr_q.pop_front());
            h_addr  = ifa.imem_addr;
            req_run = 1;
          end else begin
            check("addr_stable", ifa.imem_addr, h_addr);
            req_run++;
          end
        end else if (prev_req) begin
          if (req_len_q.size() == 0) fail_now("sb_req_len_available");
          else check("req_cycles", 32'(req_run), 32'(req_len_q.pop_front()));
        end

        if (ifa.inst_valid) begin
          check("no_req_in_hold", 32'(ifa.imem_req), 32'd0);
          if (!prev_val) begin
            if (exp_q.size() == 0) fail_now("sb_inst_available");
            else begin
              e = exp_q.pop_front();
              check("inst", ifa.inst, e.inst);
              check("ctrl_code", 32'(ifa.ctrl_code), 32'(e.ctrl));
              check("pc_out", ifa.pc_out, e.pc);
              check("pc_plus4", ifa.pc_plus4, e.pc + 32'd4);
              check("fetch_err_idle", 32'(ifa.fetch_err), 32'd0);
            end
            h_inst  = ifa.inst;
            h_pc    = ifa.pc_out;
            val_run = 1;
          end else begin
            check("inst_hold", ifa.inst, h_inst);
            check("pc_hold", ifa.pc_out, h_pc);
            val_run++;
          end
        end else if (prev_val) begin
          if (hold_len_q.size() == 0) fail_now("sb_hold_len_available");
          else check("valid_cycles", 32'(val_run), 32'(hold_len_q.pop_front()));
        end
        prev_req = ifa.imem_req;
        prev_val = ifa.inst_valid;
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    fail_now("watchdog");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset_n = 1'b0;
    rb_n    = 1'b0;
    ifa.imem_ack = 1'b0; ifa.imem_rdata = 32'h0; ifa.inst_ready = 1'b0;
    ifa.branch_taken = 1'b0; ifa.jump = 1'b0;
    ifb.imem_ack = 1'b0; ifb.imem_rdata = 32'h0; ifb.inst_ready = 1'b0;
    ifb.branch_taken = 1'b0; ifb.jump = 1'b0;

    mem[32'h00] = 32'h2008_0005;
    mem[32'h04] = 32'h012A_4020;
    mem[32'h08] = 32'h012A_4024;
    mem[32'h0C] = 32'h2008_0005;
    mem[32'h10] = 32'h1000_FFFF;
    mem[32'h14] = 32'h0800_0010;
    mem[32'h40] = 32'h0800_0100;
    plan_q.push_back('{delay: 0, stall: 0, bt: 0, jmp: 0, chk: 1, ctrl: 6'b001000, nxt: 32'h04});
    plan_q.push_back('{delay: 0, stall: 0, bt: 0, jmp: 0, chk: 1, ctrl: 6'b100000, nxt: 32'h08});
    plan_q.push_back('{delay: 0, stall: 0, bt: 0, jmp: 0, chk: 1, ctrl: 6'b100100, nxt: 32'h0C});
    plan_q.push_back('{delay: 3, stall: 0, bt: 0, jmp: 0, chk: 1, ctrl: 6'b001000, nxt: 32'h10});
    plan_q.push_back('{delay: 0, stall: 5, bt: 1, jmp: 0, chk: 1, ctrl: 6'b000100, nxt: 32'h10});
    plan_q.push_back('{delay: 0, stall: 0, bt: 0, jmp: 0, chk: 1, ctrl: 6'b000100, nxt: 32'h14});
    plan_q.push_back('{delay: 0, stall: 0, bt: 0, jmp: 1, chk: 1, ctrl: 6'b000010, nxt: 32'h40});
    plan_q.push_back('{delay: 1, stall: 2, bt: 1, jmp: 1, chk: 1, ctrl: 6'b000010, nxt: 32'h400});

    // Reset state, with a stray ack that must be ignored.
    ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    ifa.imem_ack = 1'b0;
    check("rst_imem_req", 32'(ifa.imem_req), 32'd0);
    check("rst_inst_valid", 32'(ifa.inst_valid), 32'd0);
    check("rst_fetch_err", 32'(ifa.fetch_err), 32'd0);
    check("rst_inst", ifa.inst, 32'h0);
    check("rst_pc_out", ifa.pc_out, 32'h0);
    check("rst_pc_plus4", ifa.pc_plus4, 32'h4);
    check("rst_ctrl_code", 32'(ifa.ctrl_code), 32'd0);

    addr_q.push_back(32'h0);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    @(negedge clk);
    check("first_req_latency", 32'(ifa.imem_req), 32'd1);
    run_fetch(250);
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    check("sb_drain_inst", 32'(exp_q.size()), 32'd0);
    check("sb_drain_addr", 32'(addr_q.size()), 32'd0);

    // Timeout: no ack ever; ERR after the 4th REQ cycle.
    reset_n = 1'b0;
    ifa.imem_ack = 1'b0; ifa.inst_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ifa.imem_req) cnt++;
      else break;
    end
    check("timeout_req_cycles", 32'(cnt), 32'd4);
    check("timeout_fetch_err", 32'(ifa.fetch_err), 32'd1);
    check("timeout_req_low", 32'(ifa.imem_req), 32'd0);
    check("timeout_valid_low", 32'(ifa.inst_valid), 32'd0);
    ifa.imem_ack = 1'b1; ifa.imem_rdata = 32'h1234_5678; ifa.inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(ifa.fetch_err), 32'd1);
    check("err_no_capture", ifa.inst, 32'h0);
    check("err_valid_low", 32'(ifa.inst_valid), 32'd0);
    ifa.inst_ready = 1'b0;

    // One-cycle reset pulse with ack still high: recovery at RESET_PC.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("recover_fetch_err", 32'(ifa.fetch_err), 32'd0);
    check("recover_pc", ifa.pc_out, 32'h0);
    check("recover_inst", ifa.inst, 32'h0);
    ifa.imem_rdata = 32'h2008_0005;
    @(negedge clk);
    check("recover_req", 32'(ifa.imem_req), 32'd1);
    check("recover_addr", ifa.imem_addr, 32'h0);
    @(negedge clk);
    ifa.imem_ack = 1'b0;
    check("recover_valid", 32'(ifa.inst_valid), 32'd1);
    check("recover_inst_cap", ifa.inst, 32'h2008_0005);
    check("recover_ctrl", 32'(ifa.ctrl_code), 32'b001000);

    // DUT B: jump at the top of the address space, and TIMEOUT=0 waits forever.
    rb_n = 1'b1;
    @(negedge clk);
    check("b_first_req", 32'(ifb.imem_req), 32'd1);
    check("b_first_addr", ifb.imem_addr, 32'hF000_0000);
    ifb.imem_ack = 1'b1; ifb.imem_rdata = 32'h0800_0003;
    @(negedge clk);
    ifb.imem_ack = 1'b0;
    check("b_valid", 32'(ifb.inst_valid), 32'd1);
    check("b_ctrl", 32'(ifb.ctrl_code), 32'b000010);
    check("b_pc_plus4", ifb.pc_plus4, 32'hF000_0004);
    ifb.inst_ready = 1'b1; ifb.jump = 1'b1;
    @(negedge clk);
    ifb.inst_ready = 1'b0; ifb.jump = 1'b0;
    check("b_jump_addr", ifb.imem_addr, 32'hF000_000C);
    repeat (40) @(negedge clk);
    check("b_no_timeout_req", 32'(ifb.imem_req), 32'd1);
    check("b_no_timeout_err", 32'(ifb.fetch_err), 32'd0);
    check("b_addr_held", ifb.imem_addr, 32'hF000_000C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
